// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO. It has a generic width and
//                depth, normal or show-ahead read, almost-full/almost-empty
//                thresholds, a full-range fill count, and sticky
//                overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int SHOWAHEAD = 0,
   parameter int AF_LEVEL  = 6,
   parameter int AE_LEVEL  = 2
) (
   input  logic              clk_50,
   input  logic              aclr,
   input  logic [DATA_W-1:0] data,
   input  logic              wrreq,
   input  logic              rdreq,
   input  logic              err_clr,
   output logic [DATA_W-1:0] q,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   usedw,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] USED_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_THR   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_THR   = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   usedw_q,  usedw_d;
   logic              empty_q,  empty_d;
   logic              full_q,   full_d;
   logic              ae_q,     ae_d;
   logic              af_q,     af_d;
   logic              ovf_q,    ovf_d;
   logic              udf_q,    udf_d;
   logic [DATA_W-1:0] q_q,      q_d;
   logic              wr_ok;
   logic              rd_ok;

   // Accept/reject requests against the registered flags and compute next pointer, count and status
   always_comb begin
      wr_ok    = wrreq & ~full_q;
      rd_ok    = rdreq & ~empty_q;
      wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      usedw_d  = usedw_q;
      case ({wr_ok, rd_ok})
         2'b10:   usedw_d = usedw_q + 1'b1;
         2'b01:   usedw_d = usedw_q - 1'b1;
         default: usedw_d = usedw_q;
      endcase
      empty_d = (usedw_d == '0);
      full_d  = (usedw_d == USED_MAX);
      ae_d    = (usedw_d <= AE_THR);
      af_d    = (usedw_d >= AF_THR);
      // A new error event wins over a same-cycle clear
      ovf_d   = (wrreq & full_q)  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
      udf_d   = (rdreq & empty_q) ? 1'b1 : (err_clr ? 1'b0 : udf_q);
   end

   generate
      if (SHOWAHEAD != 0) begin : g_showahead
         // Register the word that will sit at the head after this edge; a word landing
         // in the head slot this edge is taken from data so it shows as empty drops
         always_comb begin
            q_d = q_q;
            if (usedw_d != '0) begin
               if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
                  q_d = data;
               end else begin
                  q_d = mem_q[rd_ptr_d];
               end
            end
         end
      end else begin : g_normal
         // Normal read: the popped word appears one cycle after the accepted rdreq
         always_comb begin
            q_d = rd_ok ? mem_q[rd_ptr_q] : q_q;
         end
      end
   endgenerate

   // Storage array; contents are not reset
   always_ff @(posedge clk_50) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= data;
      end
   end

   // Control and status registers with asynchronous clear
   always_ff @(posedge clk_50 or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ae_q     <= 1'b1;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         q_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ae_q     <= ae_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         q_q      <= q_d;
      end
   end

   assign q            = q_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign usedw        = usedw_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
`default_nettype wire
